load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit that sits directly upstream of the word-addressed data memory.
- Accepts byte/halfword/word load and store requests from the EX/MEM pipeline register.
- Converts byte addresses to word indices and performs read-modify-write for sub-word stores.
- Extracts and sign- or zero-extends load data, and returns results to the MEM/WB register.
- Drives a stall while a multi-cycle access is in flight.

Parameters:
- MEM_WORDS, 1024, depth of the attached data memory in 32-bit words.
- ADDR_W, 32, width of the byte address from the pipeline.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- req_signed  in  1  load sign-extension enable; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse when a request completes (load data ready, store done, or fault).
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; misaligned, illegal size, or out-of-range access.
- stall  out  1  high whenever the FSM is not in IDLE.
- mem_readEn  out  1  data memory read enable.
- mem_writeEn  out  1  data memory write enable.
- mem_address  out  32  word index, i.e. req_addr[ADDR_W-1:2] zero-extended.
- mem_WriteData  out  32  full-word write data.
- mem_ReadData  in  32  memory read data; valid on the rising edge one cycle after mem_readEn was asserted.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state goes to IDLE; request registers are cleared.
  - req_ready=1; stall=0; resp_valid=0; resp_rdata=0; resp_fault=0; mem_readEn=0; mem_writeEn=0; mem_address=0; mem_WriteData=0.
- Reset mid-operation aborts the access. A pending RMW write is never issued.
- Acceptance:
  - A request is accepted when req_valid && req_ready.
  - req_ready = (state==IDLE).
  - On acceptance, req_addr, req_wdata, req_size, req_signed and req_write are latched. Inputs are ignored while the FSM is busy.
- Fault check, done on the accepted request in IDLE:
  - size 11 is a fault.
  - halfword with addr[0]=1 is a fault.
  - word with addr[1:0]≠0 is a fault.
  - On a fault there is no memory enable. The next cycle gives resp_valid=1, resp_fault=1, resp_rdata=0, then the FSM returns to IDLE.
- States: IDLE, LOAD_WAIT, RMW_MERGE, RESP.
- Transitions:
  - IDLE → RESP: word store, issued as a single write with mem_writeEn=1 and mem_WriteData=req_wdata in the accept cycle (registered outputs asserted for exactly one cycle). Also taken on any fault.
  - IDLE → LOAD_WAIT: any load; mem_readEn=1 for one cycle.
  - LOAD_WAIT → RESP: capture mem_ReadData, extract the lane selected by addr[1:0], and extend per req_signed.
  - IDLE → RMW_MERGE: byte/halfword store; mem_readEn=1.
  - RMW_MERGE → RESP: replace the addressed lane(s) of mem_ReadData with the low byte/halfword of the latched wdata; mem_writeEn=1 with the merged word.
  - RESP → IDLE: resp_valid=1 for exactly one cycle.
- Latency from acceptance to resp_valid:
  - word store: 2 cycles.
  - load: 3 cycles.
  - sub-word store: 3 cycles.
  - fault: 2 cycles.
- Lane mapping is little-endian: byte lane n = bits [8n+7:8n]; halfword at addr[1]=1 uses bits [31:16].
- Back-to-back: a new request may be accepted in the cycle after RESP.
- mem_readEn and mem_writeEn are never high in the same cycle.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- When defined: a word index ≥ MEM_WORDS is a fault with the same fault path as above and no memory enable.
- When undefined: no range check; mem_address is driven unmodified and the memory wraps or ignores per its own behaviour.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state typedef.
  - lane-mask constants.
- Sub-module lsu_align: purely combinational; load lane extract/extend and store lane merge. Instantiated once. All sequencing stays in load_store_unit.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x10 → mem_writeEn at index 4. Load word 0x10 → resp_rdata=0xDEADBEEF after 3 cycles, resp_fault=0.
- Signed/unsigned byte load: memory word at index 4 = 0x80FF7F01. Load byte signed at 0x13 → 0xFFFFFF80. Load byte unsigned at 0x12 → 0x000000FF.
- Halfword RMW store: word at index 2 = 0x11223344. Store half 0xAAAA5555 at 0x0A → memory word becomes 0x55553344, with one read then one write.
- Misaligned: load word at 0x06 → resp_valid, resp_fault=1, resp_rdata=0, no mem enable pulses. Same result for req_size=11.
- Reset mid-RMW: assert rst=0 in the cycle the FSM is in RMW_MERGE → no mem_writeEn; memory word unchanged; outputs at reset values; req_ready=1.
- Bounds (LSU_BOUNDS_CHECK_EN defined): load word at 0x1000 with MEM_WORDS=1024 → fault, no mem_readEn. With the macro undefined → mem_address=0x400 with mem_readEn pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane masks.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2,
        RESP      = 2'd3
    } lsu_state_t;

    // Illegal size or an address not naturally aligned to the access size.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Replicate the store data across lanes, then keep only the addressed lane(s).
    always_comb begin
        case (size)
            SZ_BYTE: begin
                lane_mask = LANE_MASK_BYTE << {offset, 3'b000};
                lane_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_mask = LANE_MASK_HALF << {offset[1], 4'b0000};
                lane_data = {2{wdata}};
            end
            default: begin
                lane_mask = 32'h0000_0000;
                lane_data = {2{wdata}};
            end
        endcase
        merged = (rdata & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-addressed data memory.
// Optional word-index range fault: define LSU_BOUNDS_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              stall,
    output logic              mem_readEn,
    output logic              mem_writeEn,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_WriteData,
    input  logic [31:0]       mem_ReadData
);

    if (MEM_WORDS < 1 || ADDR_W < 3 || ADDR_W > 34) begin : g_cfg_check
        $error("load_store_unit: unsupported MEM_WORDS/ADDR_W");
    end

    lsu_state_t  state, state_n;
    logic [1:0]  offset_q, offset_n;
    logic [15:0] wdata_q, wdata_n;
    logic [1:0]  size_q, size_n;
    logic        signed_q, signed_n;
    logic        fault_q, fault_n;
    logic [31:0] rdata_q, rdata_n;

    logic        resp_valid_n, resp_fault_n, mem_readEn_n, mem_writeEn_n;
    logic [31:0] resp_rdata_n, mem_address_n, mem_WriteData_n;

    logic        out_of_range;
    logic        req_fault;
    logic [31:0] load_data, merged;

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = (req_addr >> 2) >= ADDR_W'(MEM_WORDS);
`else
    assign out_of_range = 1'b0;
`endif

    assign req_fault = is_bad_access(req_size, req_addr[1:0]) || out_of_range;
    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);

    lsu_align u_align (
        .rdata     (mem_ReadData),
        .wdata     (wdata_q),
        .size      (size_q),
        .offset    (offset_q),
        .is_signed (signed_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_n         = state;
        offset_n        = offset_q;
        wdata_n         = wdata_q;
        size_n          = size_q;
        signed_n        = signed_q;
        fault_n         = fault_q;
        rdata_n         = rdata_q;
        resp_valid_n    = 1'b0;
        resp_fault_n    = 1'b0;
        resp_rdata_n    = 32'h0;
        mem_readEn_n    = 1'b0;
        mem_writeEn_n   = 1'b0;
        mem_address_n   = mem_address;
        mem_WriteData_n = mem_WriteData;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    offset_n      = req_addr[1:0];
                    wdata_n       = req_wdata[15:0];
                    size_n        = req_size;
                    signed_n      = req_signed;
                    fault_n       = req_fault;
                    rdata_n       = 32'h0;
                    mem_address_n = 32'(req_addr >> 2);
                    if (req_fault) begin
                        state_n = RESP;
                    end else if (!req_write) begin
                        mem_readEn_n = 1'b1;
                        state_n      = LOAD_WAIT;
                    end else if (req_size == SZ_WORD) begin
                        mem_writeEn_n   = 1'b1;
                        mem_WriteData_n = req_wdata;
                        state_n         = RESP;
                    end else begin
                        mem_readEn_n = 1'b1;
                        state_n      = RMW_MERGE;
                    end
                end
            end
            LOAD_WAIT: begin
                rdata_n = load_data;
                state_n = RESP;
            end
            RMW_MERGE: begin
                mem_writeEn_n   = 1'b1;
                mem_WriteData_n = merged;
                state_n         = RESP;
            end
            RESP: begin
                resp_valid_n = 1'b1;
                resp_fault_n = fault_q;
                resp_rdata_n = rdata_q;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset wins over any in-flight access, so a pending merge write is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            offset_q      <= 2'b00;
            wdata_q       <= 16'h0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            fault_q       <= 1'b0;
            rdata_q       <= 32'h0;
            resp_valid    <= 1'b0;
            resp_fault    <= 1'b0;
            resp_rdata    <= 32'h0;
            mem_readEn    <= 1'b0;
            mem_writeEn   <= 1'b0;
            mem_address   <= 32'h0;
            mem_WriteData <= 32'h0;
        end else begin
            state         <= state_n;
            offset_q      <= offset_n;
            wdata_q       <= wdata_n;
            size_q        <= size_n;
            signed_q      <= signed_n;
            fault_q       <= fault_n;
            rdata_q       <= rdata_n;
            resp_valid    <= resp_valid_n;
            resp_fault    <= resp_fault_n;
            resp_rdata    <= resp_rdata_n;
            mem_readEn    <= mem_readEn_n;
            mem_writeEn   <= mem_writeEn_n;
            mem_address   <= mem_address_n;
            mem_WriteData <= mem_WriteData_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, stall;
    logic [31:0] resp_rdata;
    logic        mem_readEn, mem_writeEn;
    logic [31:0] mem_address, mem_WriteData, mem_ReadData;

    logic [31:0] mem [0:1023];
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] rd_idx = 32'h0, wr_idx = 32'h0;

    int          checks = 0, errors = 0;
    logic [31:0] got_rdata;
    logic        got_fault;
    int          got_lat, got_rd, got_wr;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .stall         (stall),
        .mem_readEn    (mem_readEn),
        .mem_writeEn   (mem_writeEn),
        .mem_address   (mem_address),
        .mem_WriteData (mem_WriteData),
        .mem_ReadData  (mem_ReadData)
    );

    // Read data is valid at the edge following the read-enable cycle.
    assign mem_ReadData = mem[mem_address[9:0]];

    always @(posedge clk) begin
        if (mem_writeEn) begin
            mem[mem_address[9:0]] <= mem_WriteData;
            wr_cnt <= wr_cnt + 1;
            wr_idx <= mem_address;
        end
        if (mem_readEn) begin
            rd_cnt <= rd_cnt + 1;
            rd_idx <= mem_address;
        end
        if (mem_readEn && mem_writeEn) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd);
        int n, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        got_rdata = resp_rdata;
        got_fault = resp_fault;
        got_lat   = resp_valid ? n : -1;
        got_rd    = rd_cnt - rd0;
        got_wr    = wr_cnt - wr0;
    endtask

    task automatic check_req(input string tag, input logic [31:0] exp_rdata, input logic exp_fault,
                             input int exp_lat, input int exp_rd, input int exp_wr);
        check({tag, ".lat"},   32'(got_lat),   32'(exp_lat));
        check({tag, ".rdata"}, got_rdata,      exp_rdata);
        check({tag, ".fault"}, 32'(got_fault), 32'(exp_fault));
        check({tag, ".reads"}, 32'(got_rd),    32'(exp_rd));
        check({tag, ".writes"},32'(got_wr),    32'(exp_wr));
    endtask

    initial begin
        int wr_before;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.fault", 32'(resp_fault), 32'd0);
        check("rst.enables", {30'd0, mem_readEn, mem_writeEn}, 32'd0);
        check("rst.address", mem_address, 32'h0);
        check("rst.wdata", mem_WriteData, 32'h0);
        rst = 1'b1;

        // Word store, then word load of the same location.
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check_req("st_word", 32'h0, 1'b0, 2, 0, 1);
        check("st_word.idx", wr_idx, 32'd4);
        check("st_word.mem", mem[4], 32'hDEADBEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check_req("ld_word", 32'hDEADBEEF, 1'b0, 3, 1, 0);

        // Byte and halfword loads with and without sign extension.
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check_req("ld_sb13", 32'hFFFFFF80, 1'b0, 3, 1, 0);
        run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        check_req("ld_ub12", 32'h000000FF, 1'b0, 3, 1, 0);
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check("ld_sb11.rdata", got_rdata, 32'h0000007F);
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check("ld_sh12.rdata", got_rdata, 32'hFFFF80FF);
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("ld_uh12.rdata", got_rdata, 32'h000080FF);
        run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        check("ld_sh10.rdata", got_rdata, 32'h00007F01);

        // Sub-word stores via read-modify-write.
        run_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344);
        run_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'hAAAA5555);
        check_req("st_half", 32'h0, 1'b0, 3, 1, 1);
        check("st_half.mem", mem[2], 32'h55553344);
        run_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h123456AB);
        check_req("st_byte", 32'h0, 1'b0, 3, 1, 1);
        check("st_byte.mem", mem[2], 32'h5555AB44);

        // Faults: misaligned word, illegal size, odd halfword store.
        run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        check_req("flt_word", 32'h0, 1'b1, 2, 0, 0);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check_req("flt_size", 32'h0, 1'b1, 2, 0, 0);
        run_req(1'b1, 2'b01, 1'b0, 32'h0B, 32'hFFFFFFFF);
        check_req("flt_half", 32'h0, 1'b1, 2, 0, 0);
        check("flt_half.mem", mem[2], 32'h5555AB44);

        // Reset while the merge is pending must suppress the write.
        run_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344);
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_addr = 32'h08; req_wdata = 32'h000000EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_rst.stall", 32'(stall), 32'd1);
        check("rmw_rst.readEn", 32'(mem_readEn), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rmw_rst.enables", {30'd0, mem_readEn, mem_writeEn}, 32'd0);
        check("rmw_rst.ready", 32'(req_ready), 32'd1);
        check("rmw_rst.stall0", 32'(stall), 32'd0);
        check("rmw_rst.outs", {mem_address | mem_WriteData | resp_rdata}, 32'h0);
        check("rmw_rst.resp", {30'd0, resp_valid, resp_fault}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rmw_rst.writes", 32'(wr_cnt - wr_before), 32'd0);
        check("rmw_rst.mem", mem[2], 32'h11223344);

        // Word index beyond the memory depth.
        run_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
        check("bounds.fault", 32'(got_fault), 32'd1);
        check("bounds.reads", 32'(got_rd), 32'd0);
`else
        check("bounds.fault", 32'(got_fault), 32'd0);
        check("bounds.reads", 32'(got_rd), 32'd1);
        check("bounds.idx", rd_idx, 32'h400);
`endif

        check("no_overlap", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
